// File: rtl/axi4_arb_pkg.sv
// Shared types and width helpers for the AXI4 read-channel arbiter.
package axi4_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } arb_state_e;

  // Bits needed to carry a master index on the slave-side ID.
  function automatic int midx_w(input int num_mst);
    return (num_mst > 1) ? $clog2(num_mst) : 1;
  endfunction

  // Slave-side ID width: master index prepended to the master ARID.
  function automatic int sid_w(input int id_width, input int num_mst);
    return id_width + midx_w(num_mst);
  endfunction

endpackage

// File: rtl/axi4_rr_arbiter.sv
// Round-robin picker: one-hot grant searched from the rotating pointer,
// pointer advances past the winner when the grant is taken.
module axi4_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int unsigned N = NUM_REQ;

  logic [IDX_W-1:0] ptr;
  logic             found;

  // Search candidates in order ptr, ptr+1, ... (mod N); first requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (((32'(ptr) + off) % N) == j)) begin
          found     = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

  // Pointer moves to the requester after the winner once the grant is used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (upd && found) begin
      if ((32'(grant_idx) + 32'd1) == N) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// AXI4 read arbiter: N masters share one slave read port. AR requests are
// granted round-robin and reissued from registers; R beats route back by the
// master index carried in the upper bits of RID.
module axi4_rd_arbiter
  import axi4_arb_pkg::*;
#(
  parameter int NUM_MST    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 8,
  localparam int MIDX_W    = midx_w(NUM_MST),
  localparam int SID_W     = sid_w(ID_WIDTH, NUM_MST),
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [NUM_MST-1:0]             m_arvalid,
  output logic [NUM_MST-1:0]             m_arready,
  input  logic [NUM_MST*ID_WIDTH-1:0]    m_arid,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]  m_araddr,
  input  logic [NUM_MST*8-1:0]           m_arlen,
  input  logic [NUM_MST*3-1:0]           m_arsize,
  input  logic [NUM_MST*2-1:0]           m_arburst,
  output logic [NUM_MST-1:0]             m_rvalid,
  input  logic [NUM_MST-1:0]             m_rready,
  output logic [ID_WIDTH-1:0]            m_rid,
  output logic [DATA_WIDTH-1:0]          m_rdata,
  output logic [1:0]                     m_rresp,
  output logic                           m_rlast,
  output logic                           s_arvalid,
  input  logic                           s_arready,
  output logic [SID_W-1:0]               s_arid,
  output logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic [7:0]                     s_arlen,
  output logic [2:0]                     s_arsize,
  output logic [1:0]                     s_arburst,
  input  logic                           s_rvalid,
  output logic                           s_rready,
  input  logic [SID_W-1:0]               s_rid,
  input  logic [DATA_WIDTH-1:0]          s_rdata,
  input  logic [1:0]                     s_rresp,
  input  logic                           s_rlast,
  output logic [CNT_W-1:0]               outst_cnt,
  output logic                           err_rid
);

  arb_state_e state;

  logic [NUM_MST-1:0]    grant;
  logic [MIDX_W-1:0]     grant_idx;
  logic                  can_issue;
  logic                  grant_fire;
  logic                  ar_hs;
  logic                  r_done;

  logic [ID_WIDTH-1:0]   sel_id;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [7:0]            sel_len;
  logic [2:0]            sel_size;
  logic [1:0]            sel_burst;

  logic [MIDX_W-1:0]     r_idx;
  logic                  r_mapped;

  axi4_rr_arbiter #(
    .NUM_REQ (NUM_MST),
    .IDX_W   (MIDX_W)
  ) u_rr (
    .clk       (aclk),
    .rst       (areset),
    .req       (m_arvalid),
    .upd       (grant_fire),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_issue  = (outst_cnt < CNT_W'(MAX_OUTST));
  assign grant_fire = (state == ST_IDLE) && can_issue && (|m_arvalid);
  assign m_arready  = (grant_fire && !areset) ? grant : '0;

  assign ar_hs  = s_arvalid && s_arready;
  assign r_done = s_rvalid && s_rready && s_rlast;

  // Select the winning master's AR payload.
  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int unsigned i = 0; i < NUM_MST; i++) begin
      if (grant[i]) begin
        sel_id    = m_arid[i*ID_WIDTH +: ID_WIDTH];
        sel_addr  = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len   = m_arlen[i*8 +: 8];
        sel_size  = m_arsize[i*3 +: 3];
        sel_burst = m_arburst[i*2 +: 2];
      end
    end
  end

  // AR FSM: capture the granted request in IDLE, present it until accepted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      s_arvalid <= 1'b0;
      s_arid    <= '0;
      s_araddr  <= '0;
      s_arlen   <= '0;
      s_arsize  <= '0;
      s_arburst <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_fire) begin
            s_arid    <= {grant_idx, sel_id};
            s_araddr  <= sel_addr;
            s_arlen   <= sel_len;
            s_arsize  <= sel_size;
            s_arburst <= sel_burst;
            s_arvalid <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (s_arready) begin
            s_arvalid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          s_arvalid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Outstanding-burst counter; decrement saturates at zero.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      outst_cnt <= '0;
    end else if (ar_hs && !r_done) begin
      outst_cnt <= outst_cnt + 1'b1;
    end else if (!ar_hs && r_done && (outst_cnt != '0)) begin
      outst_cnt <= outst_cnt - 1'b1;
    end
  end

  assign r_idx    = s_rid[SID_W-1:ID_WIDTH];
  assign r_mapped = (32'(r_idx) < NUM_MST);

  assign m_rid   = s_rid[ID_WIDTH-1:0];
  assign m_rdata = s_rdata;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  // Route R to the master named by RID; unmapped indices are drained.
  always_comb begin
    m_rvalid = '0;
    s_rready = 1'b1;
    if (r_mapped) begin
      s_rready = 1'b0;
      for (int unsigned i = 0; i < NUM_MST; i++) begin
        if (r_idx == MIDX_W'(i)) begin
          m_rvalid[i] = s_rvalid;
          s_rready    = m_rready[i];
        end
      end
    end
  end

  // Sticky flag for R beats that map to no master.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_rid <= 1'b0;
    end else if (s_rvalid && !r_mapped) begin
      err_rid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter with three masters.
module tb_axi4_rd_arbiter;

  localparam int NUM_MST    = 3;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = 4;
  localparam int MAX_OUTST  = 8;
  localparam int SID_W      = 6;
  localparam int CNT_W      = 4;

  logic                          aclk;
  logic                          areset;
  logic [NUM_MST-1:0]            m_arvalid;
  logic [NUM_MST-1:0]            m_arready;
  logic [NUM_MST*ID_WIDTH-1:0]   m_arid;
  logic [NUM_MST*ADDR_WIDTH-1:0] m_araddr;
  logic [NUM_MST*8-1:0]          m_arlen;
  logic [NUM_MST*3-1:0]          m_arsize;
  logic [NUM_MST*2-1:0]          m_arburst;
  logic [NUM_MST-1:0]            m_rvalid;
  logic [NUM_MST-1:0]            m_rready;
  logic [ID_WIDTH-1:0]           m_rid;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic [1:0]                    m_rresp;
  logic                          m_rlast;
  logic                          s_arvalid;
  logic                          s_arready;
  logic [SID_W-1:0]              s_arid;
  logic [ADDR_WIDTH-1:0]         s_araddr;
  logic [7:0]                    s_arlen;
  logic [2:0]                    s_arsize;
  logic [1:0]                    s_arburst;
  logic                          s_rvalid;
  logic                          s_rready;
  logic [SID_W-1:0]              s_rid;
  logic [DATA_WIDTH-1:0]         s_rdata;
  logic [1:0]                    s_rresp;
  logic                          s_rlast;
  logic [CNT_W-1:0]              outst_cnt;
  logic                          err_rid;

  int vec_cnt = 0;
  int err_cnt = 0;

  axi4_rd_arbiter #(
    .NUM_MST    (NUM_MST),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_arid    (m_arid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arsize  (m_arsize),
    .m_arburst (m_arburst),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rid     (m_rid),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rlast   (m_rlast),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_arid    (s_arid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arsize  (s_arsize),
    .s_arburst (s_arburst),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rid     (s_rid),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rlast   (s_rlast),
    .outst_cnt (outst_cnt),
    .err_rid   (err_rid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: through the active edge, back to the sampling edge.
  task automatic step();
    @(posedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    areset    = 1'b1;
    m_arvalid = 3'b011;
    m_arid    = '0;
    m_araddr  = '0;
    m_arlen   = '0;
    m_arsize  = '0;
    m_arburst = '0;
    m_rready  = '0;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rid     = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    s_rlast   = 1'b0;
    m_arid[0*4 +: 4]    = 4'h3;
    m_arid[1*4 +: 4]    = 4'h5;
    m_arid[2*4 +: 4]    = 4'h9;
    m_araddr[0*32 +: 32] = 32'h0000_0100;
    m_araddr[1*32 +: 32] = 32'h0000_1000;
    m_araddr[2*32 +: 32] = 32'h0000_2000;
    m_arlen[1*8 +: 8]    = 8'd3;
    m_arsize[1*3 +: 3]   = 3'd3;
    m_arburst[1*2 +: 2]  = 2'd1;

    @(negedge aclk);
    step();
    #1;
    check_eq("rst_arready", 64'(m_arready), 64'h0);
    check_eq("rst_arvalid", 64'(s_arvalid), 64'h0);
    check_eq("rst_cnt", 64'(outst_cnt), 64'h0);
    check_eq("rst_err", 64'(err_rid), 64'h0);
    check_eq("rst_araddr", 64'(s_araddr), 64'h0);

    // Both m0 and m1 request: m0 first, then m1.
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check_eq("g0_arready", 64'(m_arready), 64'h1);
    step();
    m_arvalid = 3'b010;
    s_arready = 1'b1;
    #1;
    check_eq("g0_arvalid", 64'(s_arvalid), 64'h1);
    check_eq("g0_arid", 64'(s_arid), 64'h03);
    check_eq("g0_araddr", 64'(s_araddr), 64'h100);
    check_eq("g0_arready_issue", 64'(m_arready), 64'h0);
    step();
    s_arready = 1'b0;
    #1;
    check_eq("g0_cnt", 64'(outst_cnt), 64'h1);
    check_eq("g1_arready", 64'(m_arready), 64'h2);

    // m1 payload held while the slave stalls.
    step();
    m_arvalid = 3'b000;
    #1;
    check_eq("g1_arvalid", 64'(s_arvalid), 64'h1);
    check_eq("g1_arid", 64'(s_arid), 64'h15);
    check_eq("g1_araddr", 64'(s_araddr), 64'h1000);
    check_eq("g1_arlen", 64'(s_arlen), 64'h3);
    check_eq("g1_arsize", 64'(s_arsize), 64'h3);
    check_eq("g1_arburst", 64'(s_arburst), 64'h1);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      check_eq("hold_arvalid", 64'(s_arvalid), 64'h1);
      check_eq("hold_arid", 64'(s_arid), 64'h15);
      check_eq("hold_araddr", 64'(s_araddr), 64'h1000);
    end
    s_arready = 1'b1;
    step();
    #1;
    check_eq("g1_cnt", 64'(outst_cnt), 64'h2);
    check_eq("g1_arvalid_done", 64'(s_arvalid), 64'h0);

    // Fill to the outstanding limit from m2.
    m_arvalid = 3'b100;
    begin
      int n;
      n = 0;
      while (outst_cnt != 4'd8 && n < 40) begin
        step();
        n++;
      end
    end
    #1;
    check_eq("full_cnt", 64'(outst_cnt), 64'h8);
    check_eq("full_arready", 64'(m_arready), 64'h0);
    step();
    #1;
    check_eq("full_arready2", 64'(m_arready), 64'h0);
    check_eq("full_arvalid", 64'(s_arvalid), 64'h0);

    // R routing, master not ready: beat held back.
    s_rvalid = 1'b1;
    s_rid    = {2'd1, 4'hA};
    s_rlast  = 1'b0;
    s_rdata  = 64'hDEAD_BEEF_0123_4567;
    s_rresp  = 2'b10;
    m_rready = 3'b101;
    #1;
    check_eq("rt_rvalid", 64'(m_rvalid), 64'h2);
    check_eq("rt_rready", 64'(s_rready), 64'h0);
    check_eq("rt_rid", 64'(m_rid), 64'hA);
    check_eq("rt_rdata", 64'(m_rdata), 64'hDEAD_BEEF_0123_4567);
    check_eq("rt_rresp", 64'(m_rresp), 64'h2);
    step();
    s_rid    = {2'd2, 4'h7};
    s_rlast  = 1'b1;
    m_rready = 3'b100;
    #1;
    check_eq("rl_rvalid", 64'(m_rvalid), 64'h4);
    check_eq("rl_rready", 64'(s_rready), 64'h1);
    check_eq("rl_rid", 64'(m_rid), 64'h7);
    check_eq("rl_rlast", 64'(m_rlast), 64'h1);
    check_eq("rl_arready_full", 64'(m_arready), 64'h0);
    step();
    s_rvalid = 1'b0;
    #1;
    check_eq("rl_cnt", 64'(outst_cnt), 64'h7);
    check_eq("rl_arready", 64'(m_arready), 64'h4);
    step();
    m_arvalid = 3'b000;
    #1;
    check_eq("rl_arvalid", 64'(s_arvalid), 64'h1);
    check_eq("rl_arid", 64'(s_arid), 64'h29);
    step();
    #1;
    check_eq("refill_cnt", 64'(outst_cnt), 64'h8);

    // Drain five bursts down to 3.
    s_rvalid = 1'b1;
    s_rid    = {2'd0, 4'h3};
    s_rlast  = 1'b1;
    m_rready = 3'b001;
    repeat (5) step();
    s_rvalid = 1'b0;
    #1;
    check_eq("drain_cnt", 64'(outst_cnt), 64'h3);

    // AR and rlast handshakes in the same cycle at count 3.
    m_arvalid = 3'b001;
    #1;
    check_eq("both_arready", 64'(m_arready), 64'h1);
    step();
    m_arvalid = 3'b000;
    s_rvalid  = 1'b1;
    #1;
    check_eq("both_arvalid", 64'(s_arvalid), 64'h1);
    step();
    s_rvalid = 1'b0;
    #1;
    check_eq("both_cnt", 64'(outst_cnt), 64'h3);
    check_eq("both_arvalid_done", 64'(s_arvalid), 64'h0);

    // Extra rlast beyond zero must not wrap.
    s_rvalid = 1'b1;
    repeat (4) step();
    s_rvalid = 1'b0;
    #1;
    check_eq("sat_cnt", 64'(outst_cnt), 64'h0);

    // Unmapped master index 3 is drained and flagged.
    s_rid    = {2'd3, 4'h1};
    s_rlast  = 1'b0;
    s_rvalid = 1'b1;
    m_rready = 3'b000;
    #1;
    check_eq("err_rready", 64'(s_rready), 64'h1);
    check_eq("err_rvalid", 64'(m_rvalid), 64'h0);
    check_eq("err_pre", 64'(err_rid), 64'h0);
    step();
    s_rvalid = 1'b0;
    #1;
    check_eq("err_set", 64'(err_rid), 64'h1);
    step();
    #1;
    check_eq("err_sticky", 64'(err_rid), 64'h1);

    // Reset asserted mid-ISSUE with the pointer away from 0.
    m_arvalid = 3'b010;
    #1;
    check_eq("ra_g1_arready", 64'(m_arready), 64'h2);
    step();
    m_arvalid = 3'b011;
    s_arready = 1'b1;
    step();
    s_arready = 1'b0;
    #1;
    check_eq("ra_pre_cnt", 64'(outst_cnt), 64'h1);
    check_eq("ra_g0_arready", 64'(m_arready), 64'h1);
    step();
    #1;
    check_eq("ra_issue_arvalid", 64'(s_arvalid), 64'h1);
    #1;
    areset = 1'b1;
    #1;
    check_eq("ra_arvalid", 64'(s_arvalid), 64'h0);
    check_eq("ra_cnt", 64'(outst_cnt), 64'h0);
    check_eq("ra_arready", 64'(m_arready), 64'h0);
    check_eq("ra_err", 64'(err_rid), 64'h0);
    check_eq("ra_arid", 64'(s_arid), 64'h0);
    step();
    areset = 1'b0;
    #1;
    check_eq("post_arready", 64'(m_arready), 64'h1);
    step();
    m_arvalid = 3'b000;
    s_arready = 1'b1;
    #1;
    check_eq("post_arvalid", 64'(s_arvalid), 64'h1);
    check_eq("post_arid", 64'(s_arid), 64'h03);
    step();
    #1;
    check_eq("post_cnt", 64'(outst_cnt), 64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/axi4_rd_arbiter.md
AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

Interface
REQ-001 SHALL have parameters: NUM_MST, default 2, number of requesting masters (2..4).
REQ-002 SHALL have parameters: ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameters: DATA_WIDTH, default 64, read data width.
REQ-004 SHALL have parameters: ID_WIDTH, default 4, master-side ID width.
REQ-005 SHALL have parameters: MAX_OUTST, default 8, maximum outstanding read bursts.
REQ-006 SHALL derive MIDX_W = clog2(NUM_MST) and slave ID width SID_W = ID_WIDTH+MIDX_W.
REQ-007 Ports, in this order:
- aclk  in  1  clock
- areset  in  1  asynchronous, active-high reset
- m_arvalid/m_arready  in/out  NUM_MST  per-master AR handshake
- m_arid  in  NUM_MST*ID_WIDTH  per-master ARID
- m_araddr  in  NUM_MST*ADDR_WIDTH  per-master ARADDR
- m_arlen/m_arsize/m_arburst  in  NUM_MST*8/*3/*2  per-master burst attributes
- m_rvalid/m_rready  out/in  NUM_MST  per-master R handshake
- m_rid  out  ID_WIDTH  shared RID (low ID_WIDTH bits of s_rid)
- m_rdata/m_rresp/m_rlast  out  DATA_WIDTH/2/1  shared R payload
- s_arvalid/s_arready  out/in  1  slave AR handshake
- s_arid  out  SID_W  {master index, ARID}
- s_araddr/s_arlen/s_arsize/s_arburst  out  ADDR_WIDTH/8/3/2  granted AR payload
- s_rvalid/s_rready  in/out  1  slave R handshake
- s_rid/s_rdata/s_rresp/s_rlast  in  SID_W/DATA_WIDTH/2/1  slave R payload
- outst_cnt  out  clog2(MAX_OUTST+1)  outstanding burst count
- err_rid  out  1  sticky: R beat with unmapped master index

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> IDLE.
REQ-009 IDLE: if any m_arvalid and outst_cnt<MAX_OUTST, SHALL pick a winner by round-robin, register its AR payload, pulse m_arready[winner] that cycle, and go to ISSUE.
REQ-010 ISSUE: SHALL drive s_arvalid=1 from registers, with payload stable until s_arready; return to IDLE on the handshake cycle.
REQ-011 Grant-to-s_arvalid latency SHALL be exactly 1 cycle; at most one AR accepted per 2 cycles.
REQ-012 Round-robin SHALL start searching at (last winner+1) mod NUM_MST; after reset the pointer is 0 (master 0 highest).
REQ-013 outst_cnt SHALL +1 on s_arvalid&&s_arready, -1 on s_rvalid&&s_rready&&s_rlast; both in one cycle = unchanged.
REQ-014 At outst_cnt==MAX_OUTST, SHALL hold all m_arready low and stay in IDLE.
REQ-015 R routing SHALL be combinational (0 latency): idx=s_rid[SID_W-1:ID_WIDTH]; m_rvalid[idx]=s_rvalid; s_rready=m_rready[idx]; other m_rvalid=0.
REQ-016 If idx>=NUM_MST, SHALL force s_rready=1 (drain), assert no m_rvalid, and set err_rid until reset.
REQ-017 Decrement SHALL saturate at 0 (no wrap); increment cannot exceed MAX_OUTST by REQ-014.

Reset
REQ-018 On areset: state=IDLE, rr pointer=0, outst_cnt=0, err_rid=0, s_arvalid=0, all m_arready=0, registered payload=0; asserting areset mid-ISSUE SHALL drop s_arvalid immediately (asynchronous).

Structure
REQ-019 Package axi4_arb_pkg SHALL hold the FSM state enum and the MIDX_W/SID_W helper functions.
REQ-020 Sub-module axi4_rr_arbiter SHALL implement the round-robin picker (request vector, pointer, one-hot grant, update enable).

Verification
REQ-021 m0,m1 both arvalid from reset -> m0 granted first, s_arid={0,ARID}; next grant m1.
REQ-022 m1 arid=4'h5, araddr=0x1000, arlen=3 -> s_arid=6'h15 (NUM_MST=2: 5'h15), s_araddr=0x1000 one cycle after grant; held 3 cycles with s_arready low.
REQ-023 8 ARs issued, no R -> outst_cnt=8, m_arready stays 0; one rlast beat -> next AR granted.
REQ-024 Same cycle AR handshake and rlast handshake at outst_cnt=3 -> outst_cnt stays 3.
REQ-025 NUM_MST=3, s_rid index 3 with s_rvalid -> s_rready=1, no m_rvalid, err_rid=1 sticky.
REQ-026 areset pulsed during ISSUE -> s_arvalid=0 and outst_cnt=0 same cycle; clean grant to master 0 after release.
